wb_master_bridge: RTL

Converts the single-cycle-level `rd`/`wr` strobes that the CPU memory controller drives on its external-bus port into Wishbone B4 classic single-word read and write cycles. It sits directly downstream of the memory controller and feeds `data_o`, `busy` and `data_av` back to it. Every access is one word, with all byte lanes enabled. A transfer ends on slave `ack`, on slave `err`, or on a local timeout.

---
 rtl/wb_master_bridge_if.sv | 23 ++
 rtl/wb_master_bridge.sv | 112 +++++++++++
 2 files changed

// File: rtl/wb_master_bridge_if.sv
// Wishbone B4 classic bus between the bridge (master) and a slave.
// Signal names follow the master's point of view.
interface wb_master_bridge_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Turns memory-controller rd/wr strobes into single-word Wishbone
// classic cycles, ending on ack, err or a local timeout.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd,
    input  logic                      wr,
    input  logic [29:0]               addr_i,
    input  logic [31:0]               data_i,
    output logic [31:0]               data_o,
    output logic                      busy,
    output logic                      data_av,
    output logic                      err_o,
    wb_master_bridge_if.master        wb
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [29:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic [31:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        dout_d  = dout_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd ^ wr) begin
                    adr_d   = addr_i;
                    dat_d   = data_i;
                    we_d    = wr;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                tmo = (TIMEOUT_CYCLES != 0) &&
                      (cnt_q == CW'(TIMEOUT_CYCLES));
                // err beats ack; ack beats a timeout in the same cycle
                if (wb.wb_err_i || (tmo && !wb.wb_ack_i)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) dout_d = '0;
                end else if (wb.wb_ack_i) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (!we_q) dout_d = wb.wb_dat_i;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wb.wb_cyc_o = (state_q == BUS);
    assign wb.wb_stb_o = (state_q == BUS);
    assign wb.wb_sel_o = (state_q == BUS) ? 4'hF : 4'h0;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign busy        = (state_q == BUS);
    assign data_av     = (state_q == DONE);
    assign err_o       = (state_q == DONE) && err_q;
    assign data_o      = dout_q;

endmodule
